add_round_key_sched: RTL and testbench

- AddRoundKey stage with an on-the-fly AES-128 key schedule.
- Sits directly downstream of the MixColumns stage: consumes its 128-bit output and XORs it with the current round key.
- Generates round keys 1..10 internally from the cipher key, one per accepted round, and tracks the round count.
- Registered output, one-cycle latency; feeds the next round's SubBytes stage.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_sbox.sv | 33 +++
 rtl/add_round_key_sched.sv | 114 +++++++++++
 tb/tb_add_round_key_sched.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types.
//   NR     : number of rounds
//   KEY_W  : key / state width
//   RCON   : round constants indexed by the round of the key being expanded
package aes_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned KEY_W = 128;

  typedef logic [7:0]       aes_byte_t;
  typedef logic [31:0]      aes_word_t;
  typedef logic [KEY_W-1:0] aes_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ark_fsm_e;

  localparam logic [0:NR-1][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // {a,b,c,d} -> {b,c,d,a}
  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (same table as the SubBytes stage).
//   data : input byte
//   sub  : substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  // Entry 0 is the most significant byte of the constant.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sub = SBOX[data];

endmodule

// File: rtl/add_round_key_sched.sv
// AddRoundKey stage with on-the-fly AES-128 key schedule.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load key_i, apply round-0 key to state_i (wins over en)
//   key_i      : cipher key
//   en         : advance one round with the next expanded key
//   state_i    : state from MixColumns (plaintext on start)
//   state_o    : registered state_i ^ round key
//   round_o    : round index of the key applied to state_o
//   valid_o    : state_o updated this cycle
//   busy_o     : FSM in RUN
//   done_o     : final-round result valid
module add_round_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_i,
  input  logic         en,
  input  logic [127:0] state_i,
  output logic [127:0] state_o,
  output logic [3:0]   round_o,
  output logic         valid_o,
  output logic         busy_o,
  output logic         done_o
);

  ark_fsm_e   fsm_q, fsm_d;
  aes_state_t key_q, key_d, state_d;
  logic [3:0] round_d;
  logic       valid_d, busy_d, done_d;

  aes_word_t  w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;
  aes_state_t next_key;
  aes_byte_t  rc;

  // Next round key, combinational from key_q.
  assign {w0, w1, w2, w3} = key_q;
  assign rot = rot_word(w3);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .data (rot[8*g +: 8]),
      .sub  (sub[8*g +: 8])
    );
  end

  // round_o stays below NR while in RUN; the guard only keeps the index legal.
  assign rc       = (round_o < 4'(NR)) ? RCON[round_o] : 8'h00;
  assign t        = sub ^ {rc, 24'h000000};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // Next-state and next-output logic.
  always_comb begin
    fsm_d   = fsm_q;
    key_d   = key_q;
    state_d = state_o;
    round_d = round_o;
    valid_d = 1'b0;
    done_d  = 1'b0;

    if (start) begin
      fsm_d   = RUN;
      key_d   = key_i;
      state_d = state_i ^ key_i;
      round_d = 4'd0;
      valid_d = 1'b1;
    end else begin
      case (fsm_q)
        RUN: begin
          if (en) begin
            key_d   = next_key;
            state_d = state_i ^ next_key;
            round_d = round_o + 4'd1;
            valid_d = 1'b1;
            if (round_o == 4'(NR - 1)) begin
              done_d = 1'b1;
              fsm_d  = IDLE;
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (fsm_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      key_q   <= '0;
      state_o <= '0;
      round_o <= 4'd0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      key_q   <= key_d;
      state_o <= state_d;
      round_o <= round_d;
      valid_o <= valid_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

endmodule

// File: tb/tb_add_round_key_sched.sv
// Self-checking bench for add_round_key_sched: directed FIPS-197 vectors
// plus randomized start/en/reset traffic against a key-expansion model.
module tb_add_round_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_i;
  logic         en;
  logic [127:0] state_i;
  logic [127:0] state_o;
  logic [3:0]   round_o;
  logic         valid_o;
  logic         busy_o;
  logic         done_o;

  add_round_key_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .key_i   (key_i),
    .en      (en),
    .state_i (state_i),
    .state_o (state_o),
    .round_o (round_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0]   sbox_ref [256];
  logic [127:0] rk [11];
  logic [127:0] m_state;
  int           m_round;
  logic         m_valid, m_busy, m_done;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_S1  = 128'h046681e5e0cb199a48f8d37a2806264c;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (a^254) then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(v));
      b = inv;
      sbox_ref[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                      ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  // Full FIPS-197 key expansion into rk[0..10].
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
        t ^= {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Drive one cycle, advance the model on the edge, compare just after it.
  task automatic step(input logic s, input logic [127:0] k, input logic e,
                      input logic [127:0] si, input logic r);
    start = s; key_i = k; en = e; state_i = si; rst_n = r;
    @(posedge clk);
    m_valid = 1'b0;
    m_done  = 1'b0;
    if (!r) begin
      m_state = '0; m_round = 0; m_busy = 1'b0;
    end else if (s) begin
      expand(k);
      m_round = 0; m_state = si ^ rk[0]; m_valid = 1'b1; m_busy = 1'b1;
    end else if (e && m_busy) begin
      m_round++;
      m_state = si ^ rk[m_round];
      m_valid = 1'b1;
      if (m_round == 10) begin
        m_done = 1'b1; m_busy = 1'b0;
      end
    end
    #1;
    check("state", state_o, m_state);
    check("round", 128'(round_o), 128'(m_round));
    check("valid", 128'(valid_o), 128'(m_valid));
    check("busy",  128'(busy_o),  128'(m_busy));
    check("done",  128'(done_o),  128'(m_done));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] k;
    rst_n = 1'b0; start = 1'b0; en = 1'b0; key_i = '0; state_i = '0;
    m_state = '0; m_round = 0; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    build_sbox();

    // Reset state, then en while idle is ignored
    step(0, '0, 0, '0, 0);
    step(0, '0, 0, '0, 0);
    step(0, '0, 1, rnd128(), 1);

    // FIPS-197 rounds 0 and 1
    step(1, FIPS_KEY, 0, FIPS_PT, 1);
    check("fips_r0", state_o, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    step(0, '0, 1, FIPS_S1, 1);
    check("fips_r1", state_o, 128'ha49c7ff2689f352b6b5bea43026a5049);

    // Full schedule with zero state: state_o is each round key
    step(1, FIPS_KEY, 0, '0, 1);
    for (int r = 1; r <= 10; r++) step(0, '0, 1, '0, 1);
    check("fips_r10", state_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("done_r10", 128'(done_o), 128'd1);
    step(0, '0, 1, rnd128(), 1);
    step(0, '0, 0, '0, 1);

    // Stall after round 4, resume, restart at round 6 with start+en
    step(1, rnd128(), 0, rnd128(), 1);
    for (int r = 1; r <= 4; r++) step(0, '0, 1, rnd128(), 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, rnd128(), 1);
    for (int r = 5; r <= 6; r++) step(0, '0, 1, rnd128(), 1);
    k = rnd128();
    step(1, k, 1, rnd128(), 1);
    check("restart_round", 128'(round_o), 128'd0);
    for (int r = 1; r <= 3; r++) step(0, '0, 1, rnd128(), 1);

    // Reset at round 3, then en ignored until start
    step(0, '0, 1, rnd128(), 0);
    step(0, '0, 1, rnd128(), 1);
    step(0, '0, 1, rnd128(), 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 11) == 0), rnd128(), ($urandom_range(0, 3) != 0),
           rnd128(), ($urandom_range(0, 79) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
